wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL provide: ms_to_ws_valid  input  1  MEM stage presents an instruction.
REQ-004 SHALL provide: ws_allowin  output  1  WB can accept an instruction this cycle.
REQ-005 SHALL provide: ms_pc  input  32, ms_dest  input  5, ms_rf_we  input  4, ms_result  input  32  instruction PC, destination register, byte write enables and result (LWL/LWR partial words).
REQ-006 SHALL provide: ms_mfc0  input  1, ms_tlb  input  1  instruction is MFC0 / TLBWI-TLBR-TLBP.
REQ-007 SHALL provide: cp0_rdata  input  32  CP0 read data for the held MFC0.
REQ-008 SHALL provide: flush  input  1  exception/ERET flush from CP0.
REQ-009 SHALL provide: rf_we  output  4, rf_waddr  output  5, rf_wdata  output  32  regfile write port.
REQ-010 SHALL provide: ws_dest  output  5, ws_rf_we  output  4, ws_result  output  32, ws_mfc0  output  1, ws_tlb  output  1  forward bus to the ID-stage bypass.
REQ-011 SHALL provide: tlb_commit  output  1  one-cycle pulse when a TLB instruction retires.

Function
REQ-012 SHALL hold one instruction in a pipeline register; ws_valid set when ms_to_ws_valid & ws_allowin & !flush, cleared when the held instruction retires and none is accepted.
REQ-013 SHALL compute ws_allowin = !ws_valid | ws_ready_go; an instruction transfers only when ms_to_ws_valid & ws_allowin.
REQ-014 SHALL use states IDLE (empty), RUN (valid, non-TLB) and TLB_WAIT; a TLB instruction enters TLB_WAIT for exactly 1 extra cycle, so it holds WB 2 cycles total and ws_ready_go = 0 in its first cycle.
REQ-015 SHALL assert ws_ready_go = 1 in RUN and in the final cycle of TLB_WAIT; tlb_commit SHALL pulse in that final cycle.
REQ-016 SHALL drive rf_we = ms-latched rf_we only in the ws_ready_go cycle of a valid instruction, else 4'b0000; each instruction writes the regfile exactly once.
REQ-017 SHALL set rf_wdata = cp0_rdata when the held instruction is MFC0, else latched result; rf_waddr = latched dest.
REQ-018 SHALL drive ws_dest = latched dest only when ws_valid and latched rf_we != 0, else 5'd0; ws_rf_we and ws_result mirror rf_we and rf_wdata values, gated identically by ws_valid (not by ready_go).
REQ-019 SHALL drive ws_mfc0 and ws_tlb = latched flags & ws_valid; both 0 when empty.
REQ-020 SHALL, when flush coincides with an offered instruction, discard the offer; an instruction already in WB is not killed and retires normally.
REQ-021 SHALL, on back-to-back transfers, retire the held instruction and latch the new one on the same edge with no bubble.
REQ-022 SHALL never write register 0: rf_we forced to 0 when latched dest = 0.

Reset
REQ-023 SHALL, on reset, clear ws_valid and state to IDLE; all outputs 0 (ws_allowin = 1) until reset deasserts, including reset arriving mid-TLB_WAIT.

Configuration
REQ-024 SHALL, with DEBUG_TRACE_EN defined, add outputs debug_wb_pc 32, debug_wb_rf_we 4, debug_wb_rf_wnum 5, debug_wb_rf_wdata 32 equal to latched pc, rf_we, rf_waddr, rf_wdata in the retire cycle (we=0 otherwise); without it these ports and their logic SHALL not exist.

Verification
REQ-025 SHALL cover: ADDU dest=8 result 0x12345678 rf_we=F -> next cycle rf_we=F, rf_waddr=8, ws_dest=8, ws_result=0x12345678, ws_allowin=1.
REQ-026 SHALL cover: LWL dest=3 rf_we=4'b1100 result 0xAABB0000 -> rf_we=4'b1100, ws_rf_we=4'b1100, rf_wdata=0xAABB0000.
REQ-027 SHALL cover: TLBWI followed immediately by ADDU -> ws_allowin=0 one cycle, tlb_commit pulse on second cycle, ADDU latched next edge, ws_tlb=1 both TLB cycles.
REQ-028 SHALL cover: MFC0 dest=2, cp0_rdata=0xDEADBEEF -> ws_mfc0=1, rf_wdata=0xDEADBEEF.
REQ-029 SHALL cover: flush with ms_to_ws_valid=1 while WB empty -> ws_valid stays 0, rf_we=0, ws_dest=0.
REQ-030 SHALL cover: reset asserted asynchronously during TLB_WAIT -> all outputs 0 immediately, no tlb_commit, ws_allowin=1.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the five-stage MIPS pipeline.
// Holds one instruction, writes the register file once per instruction,
// feeds the ID-stage bypass, and stretches TLB instructions to two cycles so
// the TLB update lands before anything younger retires.
// Optional trace port: define DEBUG_TRACE_EN to add debug_wb_* outputs.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [4:0]  ms_dest,
    input  logic [3:0]  ms_rf_we,
    input  logic [31:0] ms_result,
    input  logic        ms_mfc0,
    input  logic        ms_tlb,
    input  logic [31:0] cp0_rdata,
    input  logic        flush,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  ws_dest,
    output logic [3:0]  ws_rf_we,
    output logic [31:0] ws_result,
    output logic        ws_mfc0,
    output logic        ws_tlb,
    output logic        tlb_commit
`ifdef DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, TLB_WAIT} state_t;

    state_t      state, state_next;
    logic        tlb_cnt;      // 0: first TLB cycle, 1: final TLB cycle
    logic        ws_valid;
    logic        ws_ready_go;
    logic        accept;

    logic [4:0]  dest_q;
    logic [3:0]  we_q;
    logic [31:0] result_q;
    logic        mfc0_q;
    logic        tlb_q;
    logic [31:0] wdata;

    // A flush kills only the instruction being offered, never the held one.
    assign accept = ms_to_ws_valid & ws_allowin & ~flush;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Tracks which of the two TLB cycles the held instruction is in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               tlb_cnt <= 1'b0;
        else if (accept)                         tlb_cnt <= 1'b0;
        else if (state == TLB_WAIT && !tlb_cnt)  tlb_cnt <= 1'b1;
    end

    // Pipeline register: loads on every transfer, so retire and refill share an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_q   <= 5'd0;
            we_q     <= 4'd0;
            result_q <= 32'd0;
            mfc0_q   <= 1'b0;
            tlb_q    <= 1'b0;
        end else if (accept) begin
            dest_q   <= ms_dest;
            we_q     <= ms_rf_we;
            result_q <= ms_result;
            mfc0_q   <= ms_mfc0;
            tlb_q    <= ms_tlb;
        end
    end

    // Next state: a new instruction wins over retirement to avoid a bubble.
    always_comb begin
        state_next = state;
        if (accept)           state_next = ms_tlb ? TLB_WAIT : RUN;
        else if (ws_ready_go) state_next = IDLE;
    end

    // Outputs decoded from state and the latched instruction.
    always_comb begin
        ws_valid    = (state != IDLE);
        ws_ready_go = (state == RUN) || (state == TLB_WAIT && tlb_cnt);
        ws_allowin  = !ws_valid || ws_ready_go;
        tlb_commit  = (state == TLB_WAIT) && tlb_cnt;

        wdata       = mfc0_q ? cp0_rdata : result_q;
        rf_waddr    = dest_q;
        rf_wdata    = wdata;
        // Single write, in the retire cycle; $0 is never written.
        rf_we       = (ws_valid && ws_ready_go && dest_q != 5'd0) ? we_q : 4'd0;

        // Bypass bus reflects the held instruction for its whole stay.
        ws_dest     = (ws_valid && we_q != 4'd0) ? dest_q : 5'd0;
        ws_rf_we    = ws_valid ? we_q  : 4'd0;
        ws_result   = ws_valid ? wdata : 32'd0;
        ws_mfc0     = ws_valid & mfc0_q;
        ws_tlb      = ws_valid & tlb_q;
    end

`ifdef DEBUG_TRACE_EN
    logic [31:0] pc_q;

    // PC is only needed by the trace port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       pc_q <= 32'd0;
        else if (accept) pc_q <= ms_pc;
    end

    // Trace mirrors the regfile write in the retire cycle.
    always_comb begin
        debug_wb_pc       = (ws_valid && ws_ready_go) ? pc_q : 32'd0;
        debug_wb_rf_we    = rf_we;
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end
`else
    logic unused_pc;
    assign unused_pc = ^ms_pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a cycle-age reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic [3:0]  ms_rf_we;
    logic [31:0] ms_result;
    logic        ms_mfc0;
    logic        ms_tlb;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ws_dest;
    logic [3:0]  ws_rf_we;
    logic [31:0] ws_result;
    logic        ws_mfc0;
    logic        ws_tlb;
    logic        tlb_commit;
`ifdef DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    wb_stage dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_rf_we(ms_rf_we), .ms_result(ms_result),
        .ms_mfc0(ms_mfc0), .ms_tlb(ms_tlb), .cp0_rdata(cp0_rdata), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_dest(ws_dest), .ws_rf_we(ws_rf_we), .ws_result(ws_result),
        .ws_mfc0(ws_mfc0), .ws_tlb(ws_tlb), .tlb_commit(tlb_commit)
`ifdef DEBUG_TRACE_EN
        , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the held instruction and how many cycles it has spent in WB.
    logic        m_valid;
    logic [4:0]  m_dest;
    logic [3:0]  m_we;
    logic [31:0] m_res;
    logic        m_mfc0;
    logic        m_tlb;
    int          m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_dest = 5'd0; m_we = 4'd0; m_res = 32'd0;
        m_mfc0 = 1'b0; m_tlb = 1'b0; m_age = 0;
    endtask

    function automatic logic m_ready();
        // TLB instructions need two cycles in WB, everything else one.
        return m_valid && (m_tlb ? (m_age >= 1) : 1'b1);
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] wd;
        wd = m_mfc0 ? cp0_rdata : m_res;
        chk({tag, ".allowin"},  32'(ws_allowin), 32'(!m_valid || m_ready()));
        chk({tag, ".rf_we"},    32'(rf_we), 32'((m_ready() && m_dest != 0) ? m_we : 4'd0));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_dest));
        chk({tag, ".rf_wdata"}, rf_wdata, wd);
        chk({tag, ".ws_dest"},  32'(ws_dest), 32'((m_valid && m_we != 0) ? m_dest : 5'd0));
        chk({tag, ".ws_rf_we"}, 32'(ws_rf_we), 32'(m_valid ? m_we : 4'd0));
        chk({tag, ".ws_result"}, ws_result, m_valid ? wd : 32'd0);
        chk({tag, ".ws_mfc0"},  32'(ws_mfc0), 32'(m_valid && m_mfc0));
        chk({tag, ".ws_tlb"},   32'(ws_tlb), 32'(m_valid && m_tlb));
        chk({tag, ".tlb_commit"}, 32'(tlb_commit), 32'(m_valid && m_tlb && m_age == 1));
    endtask

    task automatic model_step();
        logic allow, acc;
        allow = !m_valid || m_ready();
        acc   = ms_to_ws_valid && allow && !flush;
        if (acc) begin
            m_valid = 1'b1; m_dest = ms_dest; m_we = ms_rf_we; m_res = ms_result;
            m_mfc0 = ms_mfc0; m_tlb = ms_tlb; m_age = 0;
        end else if (m_ready()) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_age++;
        end
    endtask

    // Check current outputs, advance model, cross one clock edge.
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] d, input logic [3:0] we,
                         input logic [31:0] res, input logic mf, input logic tl,
                         input logic fl, input logic [31:0] cp0);
        ms_to_ws_valid = v; ms_dest = d; ms_rf_we = we; ms_result = res;
        ms_mfc0 = mf; ms_tlb = tl; flush = fl; cp0_rdata = cp0;
        ms_pc = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        model_reset();
        #12;
        check_model("reset");
        chk("reset.allowin_one", 32'(ws_allowin), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADDU $8
        offer(1'b1, 5'd8, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle("addu_offer");
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("addu.rf_we", 32'(rf_we), 32'hF);
        chk("addu.rf_waddr", 32'(rf_waddr), 32'd8);
        chk("addu.ws_dest", 32'(ws_dest), 32'd8);
        chk("addu.ws_result", ws_result, 32'h12345678);
        chk("addu.allowin", 32'(ws_allowin), 32'd1);
        cycle("addu_ret");

        // LWL $3, partial word
        offer(1'b1, 5'd3, 4'b1100, 32'hAABB0000, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle("lwl_offer");
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("lwl.rf_we", 32'(rf_we), 32'hC);
        chk("lwl.ws_rf_we", 32'(ws_rf_we), 32'hC);
        chk("lwl.rf_wdata", rf_wdata, 32'hAABB0000);
        cycle("lwl_ret");

        // TLBWI immediately followed by ADDU $9
        offer(1'b1, 5'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle("tlb_offer");
        offer(1'b1, 5'd9, 4'hF, 32'h00000099, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("tlb1.allowin", 32'(ws_allowin), 32'd0);
        chk("tlb1.ws_tlb", 32'(ws_tlb), 32'd1);
        chk("tlb1.commit", 32'(tlb_commit), 32'd0);
        cycle("tlb1");
        chk("tlb2.allowin", 32'(ws_allowin), 32'd1);
        chk("tlb2.ws_tlb", 32'(ws_tlb), 32'd1);
        chk("tlb2.commit", 32'(tlb_commit), 32'd1);
        cycle("tlb2");
        chk("tlb_addu.ws_dest", 32'(ws_dest), 32'd9);
        chk("tlb_addu.ws_tlb", 32'(ws_tlb), 32'd0);
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle("tlb_addu_ret");

        // MFC0 $2
        offer(1'b1, 5'd2, 4'hF, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        cycle("mfc0_offer");
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
        #1;
        chk("mfc0.ws_mfc0", 32'(ws_mfc0), 32'd1);
        chk("mfc0.rf_wdata", rf_wdata, 32'hDEADBEEF);
        cycle("mfc0_ret");

        // Flush against an offer while WB is empty
        offer(1'b1, 5'd5, 4'hF, 32'h55555555, 1'b0, 1'b0, 1'b1, 32'd0);
        cycle("flush_offer");
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("flush.rf_we", 32'(rf_we), 32'd0);
        chk("flush.ws_dest", 32'(ws_dest), 32'd0);
        chk("flush.allowin", 32'(ws_allowin), 32'd1);
        cycle("flush_after");

        // Asynchronous reset in the first TLB_WAIT cycle
        offer(1'b1, 5'd7, 4'hF, 32'h77777777, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle("tlbrst_offer");
        offer(1'b0, 5'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("tlbrst.pre_allowin", 32'(ws_allowin), 32'd0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("tlbrst.commit", 32'(tlb_commit), 32'd0);
        chk("tlbrst.allowin", 32'(ws_allowin), 32'd1);
        chk("tlbrst.ws_tlb", 32'(ws_tlb), 32'd0);
        chk("tlbrst.rf_we", 32'(rf_we), 32'd0);
        chk("tlbrst.ws_dest", 32'(ws_dest), 32'd0);
        chk("tlbrst.ws_result", ws_result, 32'd0);
        @(posedge clk); #1;
        chk("tlbrst.hold_commit", 32'(tlb_commit), 32'd0);
        check_model("tlbrst_hold");
        reset = 1'b0;
        cycle("tlbrst_release");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic kind_tlb, kind_mfc0;
            kind_tlb  = ($urandom % 5) == 0;
            kind_mfc0 = !kind_tlb && (($urandom % 5) == 0);
            offer(($urandom % 4) != 0, 5'($urandom), 4'($urandom), $urandom,
                  kind_mfc0, kind_tlb, ($urandom % 8) == 0, $urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
